// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory system: bus widths, well-known
// register addresses and the OAM DMA sequencer state encoding.
package cpu_mem_pkg;

    // CPU bus geometry, shared with the address decoder.
    localparam int unsigned CPU_ADDR_W = 16;
    localparam int unsigned CPU_DATA_W = 8;

    // Register addresses used by the sprite DMA path.
    localparam logic [CPU_ADDR_W-1:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [CPU_ADDR_W-1:0] ADDR_OAMDATA = 16'h2004;

    // OAM DMA sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StAlign,
        StRead,
        StWrite
    } dma_state_e;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA sequencer.
// Snoops CPU writes for the trigger address, halts the CPU, then copies
// XFER_LEN bytes from page {page,00..} to the OAM data port as alternating
// read/write cycles aligned to the get/put parity.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   cpu_addr_i   snooped CPU address bus
//   cpu_wdata_i  snooped CPU write data (latched as source page)
//   cpu_we_i     CPU write strobe
//   mem_rdata_i  decoded memory read data, valid while dma_re_o is high
//   cpu_halt_o   stall request to the CPU
//   bus_own_o    bus mux select: 1 = DMA drives the bus
//   dma_addr_o   DMA address (source during reads, OAM port during writes)
//   dma_re_o     DMA read strobe
//   dma_we_o     DMA write strobe
//   dma_wdata_o  DMA write data (qualified by dma_we_o)
//   dma_busy_o   transfer in progress
module oam_dma_ctrl
    import cpu_mem_pkg::*;
#(
    parameter logic [CPU_ADDR_W-1:0] TRIG_ADDR = ADDR_OAMDMA,
    parameter logic [CPU_ADDR_W-1:0] OAM_PORT  = ADDR_OAMDATA,
    parameter int unsigned           XFER_LEN  = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CPU_ADDR_W-1:0] cpu_addr_i,
    input  logic [CPU_DATA_W-1:0] cpu_wdata_i,
    input  logic                  cpu_we_i,
    input  logic [CPU_DATA_W-1:0] mem_rdata_i,
    output logic                  cpu_halt_o,
    output logic                  bus_own_o,
    output logic [CPU_ADDR_W-1:0] dma_addr_o,
    output logic                  dma_re_o,
    output logic                  dma_we_o,
    output logic [CPU_DATA_W-1:0] dma_wdata_o,
    output logic                  dma_busy_o
);

    localparam int unsigned        IDX_W    = $clog2(XFER_LEN);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(XFER_LEN - 1);
    localparam int unsigned        PAGE_W   = CPU_ADDR_W - 8;

    dma_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PAGE_W-1:0]       page_q, page_d;
    logic [CPU_DATA_W-1:0]   data_q, data_d;
    logic                    parity_q;   // 0 = get cycle, 1 = put cycle

    logic                    trig;
    logic [CPU_ADDR_W-1:0]   rd_addr;

    assign trig = cpu_we_i && (cpu_addr_i == TRIG_ADDR);

    // Index is zero-extended into the low byte; it never carries into page.
    assign rd_addr = {page_q, 8'h00} | {{(CPU_ADDR_W-IDX_W){1'b0}}, idx_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            page_q   <= '0;
            data_q   <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            page_q   <= page_d;
            data_q   <= data_d;
            parity_q <= ~parity_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    page_d  = cpu_wdata_i;
                    state_d = StHalt;
                end
            end
            StHalt: begin
                // Next cycle is a get cycle when the current one is a put.
                state_d = parity_q ? StRead : StAlign;
            end
            StAlign: begin
                state_d = StRead;
            end
            StRead: begin
                data_d  = mem_rdata_i;
                state_d = StWrite;
            end
            StWrite: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StRead;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode registered state only; no path from cpu_* inputs.
    always_comb begin
        cpu_halt_o = 1'b0;
        bus_own_o  = 1'b0;
        dma_re_o   = 1'b0;
        dma_we_o   = 1'b0;
        dma_busy_o = 1'b0;
        dma_addr_o = '0;
        unique case (state_q)
            StIdle: begin
            end
            StHalt, StAlign: begin
                cpu_halt_o = 1'b1;
                dma_busy_o = 1'b1;
            end
            StRead: begin
                cpu_halt_o = 1'b1;
                dma_busy_o = 1'b1;
                bus_own_o  = 1'b1;
                dma_re_o   = 1'b1;
                dma_addr_o = rd_addr;
            end
            StWrite: begin
                cpu_halt_o = 1'b1;
                dma_busy_o = 1'b1;
                bus_own_o  = 1'b1;
                dma_we_o   = 1'b1;
                dma_addr_o = OAM_PORT;
            end
            default: begin
            end
        endcase
    end

    assign dma_wdata_o = data_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: table of non-trigger bus accesses,
// plus full transfers checked through a scoreboard of expected DMA accesses.
module tb_oam_dma_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  mem_rdata;
    logic        cpu_halt;
    logic        bus_own;
    logic [15:0] dma_addr;
    logic        dma_re;
    logic        dma_we;
    logic [7:0]  dma_wdata;
    logic        dma_busy;

    oam_dma_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_we_i    (cpu_we),
        .mem_rdata_i (mem_rdata),
        .cpu_halt_o  (cpu_halt),
        .bus_own_o   (bus_own),
        .dma_addr_o  (dma_addr),
        .dma_re_o    (dma_re),
        .dma_we_o    (dma_we),
        .dma_wdata_o (dma_wdata),
        .dma_busy_o  (dma_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: each byte holds its low address bits XOR $A5.
    assign mem_rdata = dma_addr[7:0] ^ 8'hA5;

    // Bench view of the get/put parity: 0 in the first cycle after reset.
    logic tb_par;
    always @(posedge clk) begin
        if (rst) tb_par <= 1'b0;
        else     tb_par <= ~tb_par;
    end

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } xact_t;

    xact_t sb[$];
    logic  prev_re = 1'b0;

    // Scoreboard monitor: every DMA strobe must match the next expectation.
    always @(negedge clk) begin
        xact_t e;
        if (prev_re) chk("read_then_write", {31'd0, dma_we}, 32'd1);
        if (dma_re || dma_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_access", {15'd0, dma_we, dma_addr}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("access_kind", {31'd0, dma_we}, {31'd0, e.we});
                chk("access_addr", {16'd0, dma_addr}, {16'd0, e.addr});
                if (e.we) chk("write_data", {24'd0, dma_wdata}, {24'd0, e.data});
            end
        end
        prev_re = dma_re;
    end

    function automatic logic [20:0] outs();
        return {cpu_halt, bus_own, dma_re, dma_we, dma_busy, dma_addr};
    endfunction

    task automatic push_xfer(input logic [7:0] pg);
        for (int k = 0; k < 256; k++) begin
            sb.push_back('{we: 1'b0, addr: {pg, 8'(k)}, data: 8'h00});
            sb.push_back('{we: 1'b1, addr: 16'h2004, data: 8'(k) ^ 8'hA5});
        end
    endtask

    // want: required parity of the HALT cycle (0 get, 1 put), 2 = trigger now.
    task automatic xfer(input logic [7:0] pg, input int want);
        int   c;
        int   first_re;
        int   exp_len;
        int   exp_re;
        logic halt_par;
        if (want != 2) begin
            while (int'(tb_par) == want) @(negedge clk);
        end
        halt_par = ~tb_par;
        exp_len  = halt_par ? 513 : 514;
        exp_re   = halt_par ? 2 : 3;
        push_xfer(pg);
        cpu_addr  = 16'h4014;
        cpu_wdata = pg;
        cpu_we    = 1'b1;
        #1 chk("no_comb_path", {11'd0, outs()}, 32'd0);
        @(posedge clk);
        #1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        c        = 0;
        first_re = 0;
        do begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                chk("halt_cycle_halt", {31'd0, cpu_halt}, 32'd1);
                chk("halt_cycle_busown", {31'd0, bus_own}, 32'd0);
                chk("halt_cycle_busy", {31'd0, dma_busy}, 32'd1);
            end
            if (dma_re && first_re == 0) first_re = c;
        end while (cpu_halt && c < 700);
        chk("halt_len", c - 1, exp_len);
        chk("first_read_cycle", first_re, exp_re);
        chk("busy_falls_with_halt", {31'd0, dma_busy}, 32'd0);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic [20:0] exp_out;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int wr_cnt;
        int n;
        vecs[0] = '{addr: 16'h4015, wdata: 8'h02, we: 1'b1, exp_out: 21'd0};
        vecs[1] = '{addr: 16'h2004, wdata: 8'h02, we: 1'b1, exp_out: 21'd0};
        vecs[2] = '{addr: 16'h4014, wdata: 8'h02, we: 1'b0, exp_out: 21'd0};
        vecs[3] = '{addr: 16'h0014, wdata: 8'h03, we: 1'b1, exp_out: 21'd0};
        vecs[4] = '{addr: 16'h4004, wdata: 8'h03, we: 1'b1, exp_out: 21'd0};

        rst       = 1'b1;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {11'd0, outs()}, 32'd0);
        chk("reset_wdata", {24'd0, dma_wdata}, 32'd0);
        rst = 1'b0;

        // Non-trigger bus traffic must never start a transfer.
        foreach (vecs[i]) begin
            @(negedge clk);
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wdata;
            cpu_we    = vecs[i].we;
            @(negedge clk);
            cpu_we = 1'b0;
            chk($sformatf("no_trigger_%0d", i), {11'd0, outs()}, {11'd0, vecs[i].exp_out});
            @(negedge clk);
            chk($sformatf("no_trigger_late_%0d", i), {11'd0, outs()},
                {11'd0, vecs[i].exp_out});
        end

        @(negedge clk);
        xfer(8'h02, 0);   // HALT on get cycle: ALIGN inserted
        @(negedge clk);
        xfer(8'h02, 1);   // HALT on put cycle: straight to READ
        @(negedge clk);
        xfer(8'h40, 1);
        @(negedge clk);
        xfer(8'hFF, 0);
        xfer(8'h07, 2);   // retrigger in the first idle cycle

        // Reset during the 100th OAM write.
        @(negedge clk);
        push_xfer(8'h03);
        cpu_addr  = 16'h4014;
        cpu_wdata = 8'h03;
        cpu_we    = 1'b1;
        @(posedge clk);
        #1 cpu_we = 1'b0;
        wr_cnt = 0;
        n      = 0;
        while (wr_cnt < 100 && n < 700) begin
            @(negedge clk);
            n++;
            if (dma_we) wr_cnt++;
        end
        chk("reached_100th_write", wr_cnt, 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("reset_mid_outputs", {11'd0, outs()}, 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dma_we || cpu_halt) n++;
        end
        chk("no_activity_after_reset", n, 0);
        xfer(8'h04, 2);   // restarts from index 0

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
